// File: rtl/kyber_pkg.sv
// Shared constants, encodings and helpers for the Kyber frame collector.
// Frame lengths are in 32-bit words.
package kyber_pkg;

    localparam int CT_LEN_K2 = 192;
    localparam int CT_LEN_K3 = 272;
    localparam int CT_LEN_K4 = 392;
    localparam int PK_LEN_K2 = 200;
    localparam int PK_LEN_K3 = 296;
    localparam int PK_LEN_K4 = 392;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_K       = 2'd1,
        ERR_TIMEOUT = 2'd2,
        ERR_OVERRUN = 2'd3
    } err_code_t;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_CAPTURE = 3'd2,
        S_DONE    = 3'd3,
        S_ERR     = 3'd4
    } state_t;

    // Zero marks an illegal rank.
    function automatic logic [15:0] frame_len(
        input logic [2:0] k,
        input logic       sel
    );
        logic [15:0] len;
        len = 16'd0;
        unique case (k)
            3'd2:    len = sel ? 16'(PK_LEN_K2) : 16'(CT_LEN_K2);
            3'd3:    len = sel ? 16'(PK_LEN_K3) : 16'(CT_LEN_K3);
            3'd4:    len = sel ? 16'(PK_LEN_K4) : 16'(CT_LEN_K4);
            default: len = 16'd0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/kyber_word_ram.sv
// Simple dual-port DEPTH x 32 word buffer.
// Synchronous read, read-before-write on address collision.
module kyber_word_ram #(
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rd_data <= '0;
        else if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/kyber_frame_collector.sv
// Captures one Kyber frame into a word buffer and checks its length.
// Define KYBER_COLLECT_CSUM_EN to enable the running word checksum.
module kyber_frame_collector
    import kyber_pkg::*;
#(
    parameter int DEPTH   = 512,
    parameter int AW      = 9,
    parameter int TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [2:0]    k,
    input  logic          frame_sel,
    input  logic          valid_in,
    input  logic [31:0]   din,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [1:0]    err_code,
    output logic [AW-1:0] word_cnt,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data,
    output logic [31:0]   csum
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        state;
    state_t        state_nx;
    err_code_t     err_q;
    logic [AW-1:0] n_len;
    logic [TW-1:0] idle_cnt;
    logic [15:0]   len_sel;
    logic          k_ok;
    logic          we;
    logic          last_word;
    logic          timeout_hit;

    assign len_sel = frame_len(k, frame_sel);
    assign k_ok    = len_sel != 16'd0;

    // start always wins over a coincident word
    assign we = valid_in && !start &&
                (state == S_ARMED ||
                 (state == S_CAPTURE && word_cnt < n_len));

    assign last_word   = we && (word_cnt == n_len - AW'(1));
    assign timeout_hit = state == S_CAPTURE && !valid_in &&
                         idle_cnt == TW'(TIMEOUT - 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (start) begin
            state_nx = k_ok ? S_ARMED : S_ERR;
        end else begin
            unique case (state)
                S_ARMED:
                    if (we)
                        state_nx = last_word ? S_DONE : S_CAPTURE;
                S_CAPTURE:
                    if (last_word)
                        state_nx = S_DONE;
                    else if (timeout_hit)
                        state_nx = S_ERR;
                S_DONE:
                    if (valid_in)
                        state_nx = S_ERR;
                default: state_nx = state;
            endcase
        end
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        err  = 1'b0;
        unique case (state)
            S_ARMED, S_CAPTURE: busy = 1'b1;
            S_DONE:             done = 1'b1;
            S_ERR:              err  = 1'b1;
            default:            busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_len    <= '0;
            word_cnt <= '0;
            idle_cnt <= '0;
            err_q    <= ERR_NONE;
        end else if (start) begin
            n_len    <= len_sel[AW-1:0];
            word_cnt <= '0;
            idle_cnt <= '0;
            err_q    <= k_ok ? ERR_NONE : ERR_K;
        end else begin
            if (we)
                word_cnt <= word_cnt + AW'(1);
            if (state == S_CAPTURE && !valid_in)
                idle_cnt <= idle_cnt + TW'(1);
            else
                idle_cnt <= '0;
            if (timeout_hit)
                err_q <= ERR_TIMEOUT;
            else if (state == S_DONE && valid_in)
                err_q <= ERR_OVERRUN;
        end
    end

    assign err_code = err_q;

`ifdef KYBER_COLLECT_CSUM_EN
    logic [31:0] csum_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            csum_q <= '0;
        else if (start)
            csum_q <= '0;
        else if (we)
            csum_q <= csum_q + din;
    end

    assign csum = csum_q;
`else
    assign csum = '0;
`endif

    kyber_word_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .wr_addr (word_cnt),
        .wr_data (din),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_kyber_frame_collector.sv
// Directed self-checking bench for kyber_frame_collector.
// Expected values are hand-computed from the frame-length table.
module tb_kyber_frame_collector;

    localparam int AW = 9;

    logic          clk;
    logic          rst;
    logic          start;
    logic [2:0]    k;
    logic          frame_sel;
    logic          valid_in;
    logic [31:0]   din;
    logic          busy;
    logic          done;
    logic          err;
    logic [1:0]    err_code;
    logic [AW-1:0] word_cnt;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [31:0]   rd_data;
    logic [31:0]   csum;

    int errors = 0;
    int checks = 0;

    kyber_frame_collector #(
        .DEPTH   (512),
        .AW      (AW),
        .TIMEOUT (1024)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .k         (k),
        .frame_sel (frame_sel),
        .valid_in  (valid_in),
        .din       (din),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_code  (err_code),
        .word_cnt  (word_cnt),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .csum      (csum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d",
                   tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_csum(input logic [31:0] s);
`ifdef KYBER_COLLECT_CSUM_EN
        return s;
`else
        return 32'd0 & s;
`endif
    endfunction

    task automatic do_start(input logic [2:0] kv, input logic sel);
        k         = kv;
        frame_sel = sel;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic send(input logic [31:0] d, input int gap);
        valid_in = 1'b1;
        din      = d;
        tick();
        valid_in = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic rd(input logic [AW-1:0] a);
        rd_en   = 1'b1;
        rd_addr = a;
        tick();
        rd_en   = 1'b0;
    endtask

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        k         = 3'd0;
        frame_sel = 1'b0;
        valid_in  = 1'b0;
        din       = '0;
        rd_en     = 1'b0;
        rd_addr   = '0;
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_code", 32'(err_code), 32'd0);
        check("rst_cnt", 32'(word_cnt), 32'd0);
        check("rst_rdata", rd_data, 32'd0);
        check("rst_csum", csum, 32'd0);
        #20;
        rst = 1'b1;
        tick();

        // Words in IDLE are ignored
        send(32'd77, 0);
        send(32'd78, 0);
        check("idle_cnt", 32'(word_cnt), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        // k=3 ciphertext, 272 back-to-back words
        do_start(3'd3, 1'b0);
        check("t1_armed", 32'(busy), 32'd1);
        for (int i = 0; i < 272; i++) begin
            valid_in = 1'b1;
            din      = 32'(i);
            tick();
        end
        valid_in = 1'b0;
        check("t1_done", 32'(done), 32'd1);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_cnt", 32'(word_cnt), 32'd272);
        check("t1_csum", csum, exp_csum(32'd36856));
        rd(9'd100);
        check("t1_rd100", rd_data, 32'd100);
        rd_addr = 9'd5;
        tick();
        check("t1_rdhold", rd_data, 32'd100);

        // k=2 public key, one word every 3 cycles
        do_start(3'd2, 1'b1);
        check("t2_csum_clr", csum, 32'd0);
        check("t2_done_clr", 32'(done), 32'd0);
        for (int i = 0; i < 200; i++)
            send(32'(i), 2);
        check("t2_done", 32'(done), 32'd1);
        check("t2_cnt", 32'(word_cnt), 32'd200);
        check("t2_csum", csum, exp_csum(32'd19900));

        // Illegal k
        do_start(3'd5, 1'b0);
        check("t3_err", 32'(err), 32'd1);
        check("t3_code", 32'(err_code), 32'd1);
        check("t3_busy", 32'(busy), 32'd0);
        send(32'd1, 1);
        send(32'd2, 1);
        check("t3_cnt", 32'(word_cnt), 32'd0);
        check("t3_code2", 32'(err_code), 32'd1);

        // k=4 ciphertext, 50 words then idle timeout
        do_start(3'd4, 1'b0);
        for (int i = 0; i < 50; i++)
            send(32'(1000 + i), 0);
        repeat (1023) tick();
        check("t4_noto", 32'(err), 32'd0);
        check("t4_busy", 32'(busy), 32'd1);
        tick();
        check("t4_err", 32'(err), 32'd1);
        check("t4_code", 32'(err_code), 32'd2);
        check("t4_cnt", 32'(word_cnt), 32'd50);
        check("t4_busy2", 32'(busy), 32'd0);

        // k=2 ciphertext, 193 words -> overrun
        do_start(3'd2, 1'b0);
        check("t5_code_clr", 32'(err_code), 32'd0);
        for (int i = 0; i < 192; i++)
            send(32'(5000 + i), 0);
        check("t5_done", 32'(done), 32'd1);
        check("t5_cnt", 32'(word_cnt), 32'd192);
        send(32'd9999, 0);
        check("t5_err", 32'(err), 32'd1);
        check("t5_code", 32'(err_code), 32'd3);
        check("t5_sat", 32'(word_cnt), 32'd192);
        check("t5_csum", csum, exp_csum(32'd978336));
        rd(9'd191);
        check("t5_rd191", rd_data, 32'd5191);
        rd(9'd192);
        check("t5_rd192", rd_data, 32'd192);

        // Restart mid-capture with a coincident word
        do_start(3'd4, 1'b1);
        for (int i = 0; i < 10; i++)
            send(32'(7000 + i), 0);
        check("t6_cnt10", 32'(word_cnt), 32'd10);
        valid_in = 1'b1;
        din      = 32'hDEAD;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        valid_in = 1'b0;
        check("t6_cnt", 32'(word_cnt), 32'd0);
        check("t6_busy", 32'(busy), 32'd1);
        check("t6_done", 32'(done), 32'd0);
        check("t6_err", 32'(err), 32'd0);
        check("t6_csum", csum, 32'd0);
        rd(9'd0);
        check("t6_rd0", rd_data, 32'd7000);
        rd_en    = 1'b1;
        rd_addr  = 9'd0;
        send(32'hBEEF, 0);
        rd_en    = 1'b0;
        check("t6_rbw", rd_data, 32'd7000);
        check("t6_cnt1", 32'(word_cnt), 32'd1);
        check("t6_csum1", csum, exp_csum(32'hBEEF));
        rd(9'd0);
        check("t6_rdnew", rd_data, 32'hBEEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
